// File: rtl/hermes_local_injector.sv
// Hermes LOCAL-port packet source: turns a descriptor plus payload stream into
// header, size and payload flits behind a single registered flit slot under credit flow control.
module hermes_local_injector #(
    parameter int FLIT_SIZE = 32,
    parameter int SIZE_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [15:0]          req_target_i,
    input  logic [SIZE_W-1:0]    req_size_i,
    input  logic                 pl_valid_i,
    output logic                 pl_ready_o,
    input  logic [FLIT_SIZE-1:0] pl_data_i,
    output logic                 tx_o,
    input  logic                 credit_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 pkt_done_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    // Handshakes: a transfer happens on the rising edge where valid && ready;
    // ready never depends on valid, and valid/data hold until the transfer.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SIZE    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t                state;
    logic [SIZE_W-1:0]     size_q;
    logic [SIZE_W-1:0]     remaining;
    logic                  last_q;

    logic                  slot_free;
    logic                  req_fire;
    logic                  pl_fire;
    logic                  last_accepted;
    logic                  load;
    logic [FLIT_SIZE-1:0]  load_data;
    logic                  load_last;

    assign slot_free     = !tx_o || credit_i;
    assign req_ready_o   = rst_ni && (state == ST_IDLE) && slot_free;
    assign pl_ready_o    = (state == ST_PAYLOAD) && slot_free;
    assign req_fire      = req_valid_i && req_ready_o;
    assign pl_fire       = pl_valid_i && pl_ready_o;
    assign last_accepted = tx_o && credit_i && last_q;
    assign state_o       = state;

    // Selects what, if anything, enters the flit slot on the coming edge.
    always_comb begin
        load      = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    load      = 1'b1;
                    load_data = FLIT_SIZE'(req_target_i);
                end
            end
            ST_SIZE: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = FLIT_SIZE'(size_q);
                    load_last = (size_q == '0);
                end
            end
            ST_PAYLOAD: begin
                if (pl_fire) begin
                    load      = 1'b1;
                    load_data = pl_data_i;
                    load_last = (remaining == SIZE_W'(1));
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            size_q     <= '0;
            remaining  <= '0;
            tx_o       <= 1'b0;
            data_o     <= '0;
            last_q     <= 1'b0;
            pkt_done_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            if (load) begin
                tx_o   <= 1'b1;
                data_o <= load_data;
                last_q <= load_last;
            end else if (slot_free) begin
                tx_o   <= 1'b0;
                last_q <= 1'b0;
            end

            pkt_done_o <= last_accepted;

            // A descriptor accepted on the same edge as the last flit keeps busy high.
            if (req_fire) begin
                busy_o <= 1'b1;
            end else if (last_accepted) begin
                busy_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        size_q <= req_size_i;
                        state  <= ST_SIZE;
                    end
                end
                ST_SIZE: begin
                    if (slot_free) begin
                        if (size_q == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            remaining <= size_q;
                            state     <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (pl_fire) begin
                        remaining <= remaining - SIZE_W'(1);
                        if (remaining == SIZE_W'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hermes_local_injector.sv
// Bench for hermes_local_injector: a vector table of packets plus hand-written
// credit-hold, back-to-back and mid-packet reset sequences, checked against an expected-flit queue.
module tb_hermes_local_injector;
    localparam int FW = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [15:0]   req_target = '0;
    logic [SW-1:0] req_size = '0;
    logic          pl_valid = 1'b0;
    logic          pl_ready;
    logic [FW-1:0] pl_data = '0;
    logic          tx;
    logic          credit_i = 1'b1;
    logic [FW-1:0] data;
    logic          pkt_done;
    logic          busy;
    logic [1:0]    state;

    always #5 clk = ~clk;

    hermes_local_injector #(.FLIT_SIZE(FW), .SIZE_W(SW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_target_i(req_target), .req_size_i(req_size),
        .pl_valid_i(pl_valid), .pl_ready_o(pl_ready), .pl_data_i(pl_data),
        .tx_o(tx), .credit_i(credit_i), .data_o(data),
        .pkt_done_o(pkt_done), .busy_o(busy), .state_o(state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Credit source: random when enabled, otherwise the forced level; changes just after the edge.
    bit   rand_credit = 1'b0;
    logic credit_force = 1'b1;
    always begin
        @(posedge clk);
        #2;
        credit_i = rand_credit ? 1'($urandom_range(0, 1)) : credit_force;
    end

    // Scoreboard: {last, flit} expected in order; also models pkt_done and busy.
    logic [FW:0] exp_q[$];
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   done_cnt = 0;
    int   pl_rdy_cnt = 0;
    int   first_xfer_cyc = 0;
    int   last_xfer_cyc = 0;
    bit   arm_span = 1'b0;
    bit   abort = 1'b0;
    logic exp_done = 1'b0;
    logic exp_busy = 1'b0;
    logic mon_nd;
    logic mon_nb;
    logic [FW:0] mon_e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
        end else begin
            check("pkt_done", 64'(pkt_done), 64'(exp_done));
            check("busy", 64'(busy), 64'(exp_busy));
            mon_nd = 1'b0;
            mon_nb = exp_busy;
            if (pl_ready) pl_rdy_cnt++;
            if (pkt_done) done_cnt++;
            if (tx && credit_i) begin
                xfer_cnt++;
                last_xfer_cyc = cyc;
                if (arm_span) begin
                    first_xfer_cyc = cyc;
                    arm_span = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_flit data=0x%0h", data));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("flit_data", 64'(data), 64'(mon_e[FW-1:0]));
                    if (mon_e[FW]) begin
                        mon_nd = 1'b1;
                        mon_nb = 1'b0;
                    end
                end
            end
            if (req_valid && req_ready) mon_nb = 1'b1;
            exp_done = mon_nd;
            exp_busy = mon_nb;
        end
    end

    // Driver: pushes the expected flits, then offers the descriptor and payload.
    task automatic drive_pkt(input logic [15:0] tgt, input logic [SW-1:0] sz,
                             input logic [FW-1:0] base, input int stall_at, input int stall_len);
        int  szi;
        bit  ok;
        szi = int'(sz);
        exp_q.push_back({1'b0, FW'(tgt)});
        exp_q.push_back({1'(szi == 0), FW'(sz)});
        for (int i = 0; i < szi; i++) exp_q.push_back({1'(i == szi - 1), base + FW'(i)});
        req_target = tgt;
        req_size   = sz;
        req_valid  = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200 && !abort; c++) begin
            @(negedge clk);
            if (req_ready && !abort) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            req_valid = 1'b0;
            if (!abort) fail_now("req_handshake_timeout");
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < szi; i++) begin
            if (i == stall_at) begin
                pl_valid = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk);
                    #1;
                end
            end
            pl_valid = 1'b1;
            pl_data  = base + FW'(i);
            ok = 1'b0;
            for (int c = 0; c < 200 && !abort; c++) begin
                @(negedge clk);
                if (pl_ready && !abort) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                pl_valid = 1'b0;
                if (!abort) fail_now("pl_handshake_timeout");
                return;
            end
            @(posedge clk);
            #1;
        end
        pl_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !tx) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0]   target;
        logic [SW-1:0] size;
        logic [FW-1:0] base;
        int            stall_at;
        int            stall_len;
        bit            rnd;
        int            exp_flits;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int xs;
        int ds;
        int ps;
        int span;
        bit got;

        vecs[0] = '{16'h0203, 16'd3,  32'h0000_00A1, -1, 0, 1'b0, 5};
        vecs[1] = '{16'h0100, 16'd0,  32'h0,         -1, 0, 1'b0, 2};
        vecs[2] = '{16'h0304, 16'd4,  32'h0000_00B0,  2, 3, 1'b0, 6};
        vecs[3] = '{16'h0A0B, 16'd7,  32'h0000_00C0, -1, 0, 1'b1, 9};
        vecs[4] = '{16'hFFFF, 16'd1,  32'hDEAD_BEEF, -1, 0, 1'b1, 3};
        vecs[5] = '{16'h0000, 16'd16, $urandom,        5, 2, 1'b1, 18};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx), 64'(0));
        check("rst_data", 64'(data), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_pl_ready", 64'(pl_ready), 64'(0));
        check("rst_pkt_done", 64'(pkt_done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_state", 64'(state), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            xs = xfer_cnt;
            ds = done_cnt;
            ps = pl_rdy_cnt;
            rand_credit = vecs[v].rnd;
            arm_span = 1'b1;
            drive_pkt(vecs[v].target, vecs[v].size, vecs[v].base, vecs[v].stall_at, vecs[v].stall_len);
            wait_drain();
            rand_credit = 1'b0;
            span = last_xfer_cyc - first_xfer_cyc;
            check($sformatf("vec%0d_flits", v), 64'(xfer_cnt - xs), 64'(vecs[v].exp_flits));
            check($sformatf("vec%0d_done_pulses", v), 64'(done_cnt - ds), 64'(1));
            if (vecs[v].size == '0)
                check($sformatf("vec%0d_pl_ready_cycles", v), 64'(pl_rdy_cnt - ps), 64'(0));
            if (!vecs[v].rnd && vecs[v].stall_len == 0)
                check($sformatf("vec%0d_span", v), 64'(span), 64'(vecs[v].exp_flits - 1));
            if (!vecs[v].rnd && vecs[v].stall_len > 0)
                check($sformatf("vec%0d_gap_present", v), 64'(span > vecs[v].exp_flits - 1), 64'(1));
            @(posedge clk);
            #1;
        end

        // Header held under 4 cycles of zero credit
        credit_force = 1'b0;
        @(posedge clk);
        #3;
        xs = xfer_cnt;
        ds = done_cnt;
        fork
            drive_pkt(16'h0203, 16'd1, 32'h0000_0055, -1, 0);
            begin
                got = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (tx) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("hold_header_seen", 64'(got), 64'(1));
                if (got) begin
                    for (int c = 0; c < 4; c++) begin
                        if (c > 0) @(negedge clk);
                        check("hold_tx", 64'(tx), 64'(1));
                        check("hold_data", 64'(data), 64'(32'h0000_0203));
                    end
                end
                credit_force = 1'b1;
            end
        join
        wait_drain();
        check("hold_flits", 64'(xfer_cnt - xs), 64'(3));
        check("hold_done_pulses", 64'(done_cnt - ds), 64'(1));
        @(posedge clk);
        #1;

        // Back-to-back packets, no bubble between them
        xs = xfer_cnt;
        ds = done_cnt;
        arm_span = 1'b1;
        drive_pkt(16'h0111, 16'd2, 32'h0000_0100, -1, 0);
        drive_pkt(16'h0222, 16'd1, 32'h0000_0200, -1, 0);
        wait_drain();
        check("b2b_flits", 64'(xfer_cnt - xs), 64'(7));
        check("b2b_done_pulses", 64'(done_cnt - ds), 64'(2));
        check("b2b_span", 64'(last_xfer_cyc - first_xfer_cyc), 64'(6));
        @(posedge clk);
        #1;

        // Reset after the 2nd payload flit of a size-5 packet
        xs = xfer_cnt;
        fork
            drive_pkt(16'h0305, 16'd5, 32'h0000_0E00, -1, 0);
            begin
                got = 1'b0;
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    if (xfer_cnt - xs >= 4) begin
                        got = 1'b1;
                        break;
                    end
                end
                check("reset_point_reached", 64'(got), 64'(1));
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                abort = 1'b1;
                exp_q.delete();
                #1;
                check("async_rst_tx", 64'(tx), 64'(0));
                check("async_rst_busy", 64'(busy), 64'(0));
                check("async_rst_pkt_done", 64'(pkt_done), 64'(0));
                check("async_rst_req_ready", 64'(req_ready), 64'(0));
            end
        join
        req_valid = 1'b0;
        pl_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        check("post_rst_state", 64'(state), 64'(0));
        check("post_rst_req_ready", 64'(req_ready), 64'(1));
        check("post_rst_tx", 64'(tx), 64'(0));
        @(posedge clk);
        #1;
        xs = xfer_cnt;
        ds = done_cnt;
        drive_pkt(16'h0406, 16'd2, 32'h0000_0F00, -1, 0);
        wait_drain();
        check("post_rst_flits", 64'(xfer_cnt - xs), 64'(4));
        check("post_rst_done_pulses", 64'(done_cnt - ds), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
